// File: rtl/pipe_stage_hs_if.sv
// pipe_stage_hs_if: upstream/downstream valid-ready bundle of an elastic pipeline stage
interface pipe_stage_hs_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: elastic pipeline stage with 2-entry skid buffer, flush and bubble control zeroing
module pipe_stage_hs #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CLEAR_DATA = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  pipe_stage_hs_if.slave bus,
  output logic [1:0] count
);
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic acc, pop;
  assign bus.out_valid = count != 2'd0;
  assign bus.in_ready = count != 2'd2;
  assign acc = bus.in_valid & bus.in_ready;
  assign pop = bus.out_valid & bus.out_ready;
  // bubbles never carry control, so an empty stage cannot trigger a write
  assign bus.out_ctrl = bus.out_valid ? main_ctrl : '0;
  assign bus.out_data = (CLEAR_DATA != 0 && !bus.out_valid) ? '0 : main_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= 2'd0;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, acc} - {1'b0, pop};
      if (count == 2'd2 && pop) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end else if (acc && (count == 2'd0 || pop)) begin
        main_data <= bus.in_data;
        main_ctrl <= bus.in_ctrl;
      end
      if (acc && count == 2'd1 && !pop) begin
        skid_data <= bus.in_data;
        skid_ctrl <= bus.in_ctrl;
      end
    end
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed checks on a 32/4 hold-data stage and scoreboard run on a 64/6 clear-data stage
module tb_pipe_stage_hs;
  logic clk, reset, flush;
  logic [1:0] count_a, count_b;
  int checks, errors;
  pipe_stage_hs_if #(.DATA_W(32), .CTRL_W(4)) a ();
  pipe_stage_hs_if #(.DATA_W(64), .CTRL_W(6)) b ();
  pipe_stage_hs #(.DATA_W(32), .CTRL_W(4), .CLEAR_DATA(0)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .bus(a), .count(count_a)
  );
  pipe_stage_hs #(.DATA_W(64), .CTRL_W(6), .CLEAR_DATA(1)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .bus(b), .count(count_b)
  );
  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (count_a !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_a); end
    checks++; if (a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", a.out_valid); end
    checks++; if (a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", a.in_ready); end
    checks++; if (a.out_ctrl !== 4'h0) begin errors++; $display("FAIL reset_out_ctrl got %h exp 0", a.out_ctrl); end
    checks++; if (a.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", a.out_data); end
    @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic test_stream;
    logic [31:0] d;
    a.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      d = 32'h10 + 32'(4 * i);
      a.in_valid = 1; a.in_data = d; a.in_ctrl = 4'(i + 1);
      tick();
      checks++; if (a.out_valid !== 1'b1 || a.out_data !== d) begin errors++; $display("FAIL stream_data[%0d] got v=%b %h exp v=1 %h", i, a.out_valid, a.out_data, d); end
      checks++; if (a.out_ctrl !== 4'(i + 1)) begin errors++; $display("FAIL stream_ctrl[%0d] got %h exp %h", i, a.out_ctrl, 4'(i + 1)); end
      checks++; if (count_a !== 2'd1 || a.in_ready !== 1'b1) begin errors++; $display("FAIL stream_count[%0d] got count=%0d rdy=%b exp count=1 rdy=1", i, count_a, a.in_ready); end
    end
    a.in_valid = 0;
    tick();
    checks++; if (count_a !== 2'd0 || a.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got count=%0d v=%b exp 0 0", count_a, a.out_valid); end
    checks++; if (a.out_ctrl !== 4'h0) begin errors++; $display("FAIL bubble_ctrl_hold got %h exp 0", a.out_ctrl); end
    checks++; if (a.out_data !== 32'h18) begin errors++; $display("FAIL bubble_data_hold got %h exp 00000018", a.out_data); end
  endtask

  task automatic test_stall;
    a.out_ready = 0;
    a.in_valid = 1; a.in_data = 32'hA; a.in_ctrl = 4'b1001;
    tick();
    checks++; if (count_a !== 2'd1 || a.out_data !== 32'hA) begin errors++; $display("FAIL stall_first got count=%0d %h exp 1 0000000a", count_a, a.out_data); end
    a.in_data = 32'hB; a.in_ctrl = 4'b0010;
    tick();
    checks++; if (count_a !== 2'd2 || a.in_ready !== 1'b0) begin errors++; $display("FAIL stall_full got count=%0d rdy=%b exp 2 0", count_a, a.in_ready); end
    checks++; if (a.out_data !== 32'hA || a.out_ctrl !== 4'b1001) begin errors++; $display("FAIL stall_head got %h/%h exp 0000000a/9", a.out_data, a.out_ctrl); end
    a.in_valid = 0;
    tick();
    checks++; if (count_a !== 2'd2 || a.out_data !== 32'hA || a.out_ctrl !== 4'b1001) begin errors++; $display("FAIL stall_hold got count=%0d %h/%h exp 2 0000000a/9", count_a, a.out_data, a.out_ctrl); end
    a.out_ready = 1;
    tick();
    checks++; if (count_a !== 2'd1 || a.in_ready !== 1'b1) begin errors++; $display("FAIL skid_pop1 got count=%0d rdy=%b exp 1 1", count_a, a.in_ready); end
    checks++; if (a.out_data !== 32'hB || a.out_ctrl !== 4'b0010) begin errors++; $display("FAIL skid_second got %h/%h exp 0000000b/2", a.out_data, a.out_ctrl); end
    tick();
    checks++; if (count_a !== 2'd0 || a.out_valid !== 1'b0 || a.out_ctrl !== 4'h0) begin errors++; $display("FAIL skid_pop2 got count=%0d v=%b ctrl=%h exp 0 0 0", count_a, a.out_valid, a.out_ctrl); end
    a.out_ready = 0;
  endtask

  task automatic test_flush;
    a.out_ready = 0;
    a.in_valid = 1; a.in_ctrl = 4'hF;
    a.in_data = 32'h1; tick();
    a.in_data = 32'h2; tick();
    checks++; if (count_a !== 2'd2) begin errors++; $display("FAIL flush_fill got %0d exp 2", count_a); end
    a.in_data = 32'h3; flush = 1;
    tick();
    flush = 0;
    checks++; if (count_a !== 2'd0 || a.out_valid !== 1'b0 || a.out_ctrl !== 4'h0) begin errors++; $display("FAIL flush_full got count=%0d v=%b ctrl=%h exp 0 0 0", count_a, a.out_valid, a.out_ctrl); end
    a.in_data = 32'h1; tick();
    a.in_data = 32'h3; flush = 1;
    tick();
    flush = 0;
    checks++; if (count_a !== 2'd0 || a.out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_acc got count=%0d v=%b exp 0 0", count_a, a.out_valid); end
    a.in_valid = 0; a.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a.out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak[%0d] got v=%b data=%h exp v=0", i, a.out_valid, a.out_data); end
    end
    a.in_valid = 1; a.in_data = 32'h5; a.in_ctrl = 4'h6;
    tick();
    a.in_valid = 0;
    checks++; if (a.out_data !== 32'h5 || a.out_ctrl !== 4'h6) begin errors++; $display("FAIL flush_recover got %h/%h exp 00000005/6", a.out_data, a.out_ctrl); end
    tick();
  endtask

  task automatic test_clear_data;
    b.out_ready = 1;
    b.in_valid = 1; b.in_data = 64'hDEAD_BEEF_0123_4567; b.in_ctrl = 6'h3F;
    tick();
    checks++; if (b.out_data !== 64'hDEAD_BEEF_0123_4567 || b.out_ctrl !== 6'h3F) begin errors++; $display("FAIL clear_load got %h/%h exp deadbeef01234567/3f", b.out_data, b.out_ctrl); end
    b.in_valid = 0;
    tick();
    checks++; if (b.out_valid !== 1'b0 || b.out_data !== 64'h0 || b.out_ctrl !== 6'h0) begin errors++; $display("FAIL clear_bubble got v=%b %h/%h exp 0 0/0", b.out_valid, b.out_data, b.out_ctrl); end
    b.out_ready = 0;
  endtask

  task automatic test_async_reset;
    a.out_ready = 0; a.in_valid = 1; a.in_ctrl = 4'h3;
    a.in_data = 32'h21; tick();
    a.in_data = 32'h22; tick();
    a.in_valid = 0;
    checks++; if (count_a !== 2'd2) begin errors++; $display("FAIL areset_fill got %0d exp 2", count_a); end
    #2 reset = 1;
    #1;
    checks++; if (count_a !== 2'd0 || a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin errors++; $display("FAIL areset_mid got count=%0d v=%b rdy=%b exp 0 0 1", count_a, a.out_valid, a.in_ready); end
    @(posedge clk);
    #1 reset = 0;
    a.out_ready = 1;
    tick();
    checks++; if (a.out_valid !== 1'b0) begin errors++; $display("FAIL areset_stale got v=%b data=%h exp v=0", a.out_valid, a.out_data); end
    a.in_valid = 1; a.in_data = 32'h77; a.in_ctrl = 4'h8;
    tick();
    a.in_valid = 0;
    checks++; if (a.out_valid !== 1'b1 || a.out_data !== 32'h77 || a.out_ctrl !== 4'h8) begin errors++; $display("FAIL areset_first got v=%b %h/%h exp 1 00000077/8", a.out_valid, a.out_data, a.out_ctrl); end
    tick();
  endtask

  task automatic test_random;
    logic [63:0] qd[$];
    logic [5:0] qc[$];
    logic acc, pop;
    for (int n = 0; n < 10000; n++) begin
      checks++; if (count_b !== 2'(qd.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d exp %0d", n, count_b, qd.size()); end
      checks++; if (b.in_ready !== (qd.size() != 2)) begin errors++; $display("FAIL rand_in_ready[%0d] got %b with %0d held", n, b.in_ready, qd.size()); end
      if (!b.out_valid) begin
        checks++; if (b.out_ctrl !== 6'h0 || b.out_data !== 64'h0) begin errors++; $display("FAIL rand_bubble[%0d] got %h/%h exp 0/0", n, b.out_data, b.out_ctrl); end
      end
      b.in_valid = (n < 9980) && ($urandom_range(0, 3) != 0);
      b.out_ready = (n >= 9980) || ($urandom_range(0, 2) != 0);
      b.in_data = {$urandom, $urandom};
      b.in_ctrl = 6'($urandom);
      acc = b.in_valid && b.in_ready;
      pop = b.out_valid && b.out_ready;
      if (pop) begin
        checks++;
        if (qd.size() == 0) begin errors++; $display("FAIL rand_spurious[%0d] got %h with nothing expected", n, b.out_data); end
        else begin
          if (b.out_data !== qd[0] || b.out_ctrl !== qc[0]) begin errors++; $display("FAIL rand_order[%0d] got %h/%h exp %h/%h", n, b.out_data, b.out_ctrl, qd[0], qc[0]); end
          void'(qd.pop_front());
          void'(qc.pop_front());
        end
      end
      if (acc) begin
        qd.push_back(b.in_data);
        qc.push_back(b.in_ctrl);
      end
      tick();
    end
    checks++; if (qd.size() != 0 || b.out_valid !== 1'b0) begin errors++; $display("FAIL rand_loss got %0d outstanding v=%b exp 0 0", qd.size(), b.out_valid); end
    b.in_valid = 0; b.out_ready = 0;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1; flush = 0;
    a.in_valid = 0; a.in_data = '0; a.in_ctrl = '0; a.out_ready = 0;
    b.in_valid = 0; b.in_data = '0; b.in_ctrl = '0; b.out_ready = 0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_clear_data();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
